// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial UART transmitter with an integrated write-side byte FIFO. The system
// side pushes bytes through a FIFO-style write port. The block drains them in
// order and serializes each one onto TXo as a start bit, DATA_WIDTH data bits
// (LSB first), an optional even-parity bit and one stop bit.
//
// Parameters
//   DATA_WIDTH  bits per character
//   FIFO_DEPTH  FIFO entries (power of 2, >= 2)
//   CLK_DIV     CLKip cycles per serial bit (>= 2)
//
// Ports
//   CLKip   in   system clock, rising edge
//   RSTi    in   synchronous active-low reset
//   DATAi   in   byte to transmit
//   WEi     in   write strobe; accepted when FULLo=0
//   FULLo   out  FIFO holds FIFO_DEPTH entries
//   EMPTYo  out  FIFO holds no entries
//   TXo     out  serial line, idle high, registered
//   BUSYo   out  frame in progress
//
// Build option
//   UART_TX_PARITY_EN  when defined, a PARITY bit (XOR of the data bits) is
//                      sent between the last data bit and the stop bit.
//
// Reset clears the pointers, the count and the frame state. The FIFO storage
// is left untouched: the pointers make any old contents unreachable.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 868
) (
  input  logic                  CLKip,
  input  logic                  RSTi,
  input  logic [DATA_WIDTH-1:0] DATAi,
  input  logic                  WEi,
  output logic                  FULLo,
  output logic                  EMPTYo,
  output logic                  TXo,
  output logic                  BUSYo
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  // Frame state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [2:0]            state_q,    state_d;
  logic [BW-1:0]         baud_cnt_q, baud_cnt_d;
  logic [IW-1:0]         bit_idx_q,  bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic                  tx_q,       tx_d;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  baud_end;

  // Flags come straight from the registered count, so a write on the
  // same edge as a pop cannot sneak into a full FIFO.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign push     = WEi & ~full;
  assign baud_end = (baud_cnt_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    // Bit timer runs whenever a frame is on the wire
    if (state_q != ST_IDLE) begin
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) pop = 1'b1;
      end

      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^shift_q;      // even parity over the data bits
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shift_q[bit_idx_d];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        // Reloading on the last stop cycle gives back-to-back frames
        // with no idle gap; otherwise the line rests high in IDLE.
        if (baud_end) begin
          if (!empty) pop = 1'b1;
          else        state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Loader: fetch the head byte and begin the start bit immediately
    if (pop) begin
      shift_d    = mem_q[rd_ptr_q];
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      tx_d       = 1'b0;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLKip) begin
    if (!RSTi) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Storage has no reset; a write is only committed outside reset
  always_ff @(posedge CLKip) begin
    if (RSTi && push) mem_q[wr_ptr_q] <= DATAi;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign FULLo  = full;
  assign EMPTYo = empty;
  assign TXo    = tx_q;
  assign BUSYo  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Drives uart_tx (CLK_DIV=4, FIFO_DEPTH=16, DATA_WIDTH=8) with directed and
// random writes. A frame-level reference model (byte queue plus a countdown
// over the expected frame bits) predicts TXo/BUSYo/EMPTYo/FULLo every cycle,
// and a software UART receiver decodes the line for an end-to-end byte check.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DIV   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          we_i = 1'b0;
  logic          full_o, empty_o, tx_o, busy_o;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
    .CLKip (clk),
    .RSTi  (rst_n),
    .DATAi (data_i),
    .WEi   (we_i),
    .FULLo (full_o),
    .EMPTYo(empty_o),
    .TXo   (tx_o),
    .BUSYo (busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] fq[$];      // FIFO contents
  logic [DW-1:0] exp_q[$];   // bytes that should appear on the line
  logic [DW-1:0] cur;        // byte of the frame on the wire
  int            rem = 0;    // cycles left in current frame, 0 = idle

  function automatic logic frame_bit(input logic [DW-1:0] b, input int j);
    int k;
    k = j / DIV;
    if (k == 0) return 1'b0;
    if (k <= DW) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [DW-1:0] d);
    bit load, acc;
    if (!rst) begin
      if (rem > 0) void'(exp_q.pop_back());   // aborted frame never completes
      fq.delete();
      rem = 0;
    end else begin
      load = (rem <= 1) && (fq.size() != 0);
      acc  = we && (fq.size() != DEPTH);
      if (load) begin
        cur = fq.pop_front();
        exp_q.push_back(cur);
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (acc) fq.push_back(d);
    end
  endtask

  // ---------------- software receiver ----------------
  logic [DW-1:0] rx_q[$];
  int            mcnt = -1;
  logic [10:0]   mbits;

  task automatic monitor(input logic rst, input logic tx);
    if (!rst) begin
      mcnt = -1;
      return;
    end
    if (mcnt < 0) begin
      if (tx == 1'b0) mcnt = 0;
    end else begin
      mcnt++;
    end
    if (mcnt >= 0 && (mcnt % DIV) == DIV / 2) begin
      mbits[mcnt / DIV] = tx;
      if (mcnt / DIV == NB - 1) begin
        chk("rx_start", mbits[0], 1'b0);
        chk("rx_stop", mbits[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
        chk("rx_parity", mbits[9], ^mbits[8:1]);
`endif
        rx_q.push_back(mbits[8:1]);
        mcnt = -1;
      end
    end
  endtask

  // ---------------- per-cycle driver/checker ----------------
  logic tx_log[$];
  int   busy_n   = 0;
  bit   saw_full = 0;

  task automatic tick(input logic rst, input logic we, input logic [DW-1:0] d);
    logic m_tx;
    rst_n  = rst;
    we_i   = we;
    data_i = d;
    @(posedge clk);
    model_edge(rst, we, d);
    #1;
    m_tx = (rem > 0) ? frame_bit(cur, FRAME - rem) : 1'b1;
    chk("txo", tx_o, m_tx);
    chk("busy", busy_o, rem > 0);
    chk("empty", empty_o, fq.size() == 0);
    chk("full", full_o, fq.size() == DEPTH);
    tx_log.push_back(tx_o);
    if (busy_o) busy_n++;
    if (full_o) saw_full = 1;
    monitor(rst, tx_o);
  endtask

  task automatic run_single(input logic [DW-1:0] b, input logic [10:0] pat);
    tx_log.delete();
    busy_n = 0;
    tick(1'b1, 1'b1, b);
    repeat (FRAME + 4) tick(1'b1, 1'b0, '0);
    for (int k = 0; k < NB; k++)
      chk($sformatf("single_%h_bit%0d", b, k), tx_log[1 + k*DIV + DIV/2], pat[k]);
    chk($sformatf("single_%h_len", b), busy_n, FRAME);
  endtask

  initial begin
    logic [10:0] pat_a5, pat_01;
`ifdef UART_TX_PARITY_EN
    pat_a5 = 11'b10101001010;
    pat_01 = 11'b11000000010;
`else
    pat_a5 = 11'b01101001010;
    pat_01 = 11'b01000000010;
`endif

    // Reset held with writes attempted; nothing may start afterwards
    repeat (3) tick(1'b0, 1'b1, DW'($urandom));
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    busy_n = 0;
    repeat (10) tick(1'b1, 1'b0, '0);
    chk("post_rst_idle", busy_n, 0);

    // Single frames with fixed expected bit patterns
    run_single(8'hA5, pat_a5);
    run_single(8'h01, pat_01);

    // Back-to-back frames must be contiguous
    busy_n = 0;
    tick(1'b1, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'hFF);
    repeat (2*FRAME + 4) tick(1'b1, 1'b0, '0);
    chk("b2b_len", busy_n, 2*FRAME);

    // Overfill while a frame is in flight: one write should be dropped
    tick(1'b1, 1'b1, 8'hEE);
    repeat (2) tick(1'b1, 1'b0, '0);
    saw_full = 0;
    for (int i = 0; i <= 16; i++) tick(1'b1, 1'b1, DW'(i));
    chk("fill_full_seen", saw_full, 1'b1);
    repeat (18*FRAME + 8) tick(1'b1, 1'b0, '0);

    // Reset during DATA of 0x3C with four bytes queued
    tick(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, DW'(8'h40 + i));
    repeat (6) tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("midrst_tx", tx_o, 1'b1);
    chk("midrst_empty", empty_o, 1'b1);
    busy_n = 0;
    repeat (60) tick(1'b1, 1'b0, '0);
    chk("midrst_quiet", busy_n, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      tick(1'b1, ($urandom_range(0, 5) == 0), DW'($urandom));
    repeat (18*FRAME + 8) tick(1'b1, 1'b0, '0);

    // End-to-end byte stream
    chk("stream_len", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("stream_%0d", i), rx_q[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
